p_uart_recv: RTL and testbench

P_UART_RECV -- requirements
Module: p_uart_recv

---
 rtl/p_uart_recv.sv | 252 +++++++++++++++++++++++++
 tb/tb_p_uart_recv.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_uart_recv.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// p_uart_recv
// 8N1 UART receiver that packs eight consecutive bytes into one 64-bit word.
// Each byte lands in its slot of an assembly register, LSB byte first. When
// the eighth byte's stop bit is good, the word is published on uart_data.
// A bad stop bit abandons the whole partial word. So does an idle gap of
// TIMEOUT_BITS bit periods.
//
// Parameters
//   CLK_FREQ     system clock frequency in Hz
//   UART_BPS     baud rate; BPS_CNT = CLK_FREQ/UART_BPS clocks per bit
//   TIMEOUT_BITS idle bit periods before a partial word is dropped
//
// Ports
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   synchronous active-low reset
//   uart_rxd   in   asynchronous serial line, idle high
//   uart_done  out  one-cycle pulse, 64-bit word complete
//   uart_data  out  last complete word, byte k at [8k+7:8k]
//   rx_busy    out  high while a frame is in progress
//   byte_cnt   out  bytes of the current word received so far (0..7)
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   timeout    out  one-cycle pulse, partial word dropped on idle timeout
// ---------------------------------------------------------------------------
module p_uart_recv #(
  parameter int CLK_FREQ     = 50000000,
  parameter int UART_BPS     = 9600,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic        uart_done,
  output logic [63:0] uart_data,
  output logic        rx_busy,
  output logic [3:0]  byte_cnt,
  output logic        frame_err,
  output logic        timeout
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int CNT_W    = $clog2(BPS_CNT + 1);
  localparam int TO_LIMIT = TIMEOUT_BITS * BPS_CNT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BPS_CNT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_rxd_d0;
  logic              r_rxd_d1;
  logic              r_rxd_d2;

  logic [CNT_W-1:0]  r_clk_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic [55:0]       r_asm;
  logic [3:0]        r_byte_cnt;
  logic [TO_W-1:0]   r_idle_tmr;
  logic [63:0]       r_uart_data;
  logic              r_done;
  logic              r_frame_err;
  logic              r_timeout;

  logic              w_start;
  logic              w_cnt_last;
  logic              w_cnt_half;
  logic              w_stop_evt;
  logic              w_stop_ok;
  logic              w_stop_bad;
  logic              w_word_full;
  logic              w_tmr_run;
  logic              w_to_fire;
  logic              w_cnt_clr;

  // Synchronizer: d0/d1 resolve metastability, d2 keeps the previous
  // synchronized value so a falling edge can be seen.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_rxd_d0 <= 1'b1;
      r_rxd_d1 <= 1'b1;
      r_rxd_d2 <= 1'b1;
    end else begin
      r_rxd_d0 <= uart_rxd;
      r_rxd_d1 <= r_rxd_d0;
      r_rxd_d2 <= r_rxd_d1;
    end
  end

  assign w_start     = (r_state == S_IDLE) && r_rxd_d2 && !r_rxd_d1;
  assign w_cnt_last  = (r_clk_cnt == CNT_LAST);
  assign w_cnt_half  = (r_clk_cnt == CNT_HALF);
  assign w_stop_evt  = (r_state == S_STOP) && w_cnt_last;
  assign w_stop_ok   = w_stop_evt && r_rxd_d1;
  assign w_stop_bad  = w_stop_evt && !r_rxd_d1;
  assign w_word_full = (r_byte_cnt == 4'd7);

  // The idle timer only runs while a partial word is pending. A start edge
  // on the expiry cycle takes priority, so no timeout fires in that case.
  assign w_tmr_run   = (r_state == S_IDLE) && (r_byte_cnt != 4'd0) && !w_start;
  assign w_to_fire   = w_tmr_run && (r_idle_tmr == TO_LAST);

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = S_START;
        end
      end
      S_START: begin
        // Mid start bit: line back high means it was only a glitch.
        if (w_cnt_half) begin
          w_next = r_rxd_d1 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_cnt_last && (r_bit_idx == 3'd7)) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (w_cnt_last) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // FSM output logic
  always_comb begin
    rx_busy = (r_state != S_IDLE);
  end

  // Bit-period counter. It restarts at every sampling point, and it also
  // restarts on the mid-start-bit decision. From then on each DATA/STOP
  // sample lands in the middle of its bit.
  always_comb begin
    w_cnt_clr = 1'b0;
    case (r_state)
      S_IDLE:  w_cnt_clr = 1'b1;
      S_START: w_cnt_clr = w_cnt_half;
      S_DATA:  w_cnt_clr = w_cnt_last;
      S_STOP:  w_cnt_clr = w_cnt_last;
      default: w_cnt_clr = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_clk_cnt <= '0;
    end else if (w_cnt_clr) begin
      r_clk_cnt <= '0;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_bit_idx <= 3'd0;
    end else if (r_state != S_DATA) begin
      r_bit_idx <= 3'd0;
    end else if (w_cnt_last) begin
      r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  // Serial-to-parallel: LSB first, one bit per mid-bit sample
  always_ff @(posedge sys_clk) begin
    if ((r_state == S_DATA) && w_cnt_last) begin
      r_shift[r_bit_idx] <= r_rxd_d1;
    end
  end

  // Word assembly. Slots 0..6 are held here. The eighth byte goes straight
  // from the shift register into uart_data, so slots that stale or partial
  // words left behind never reach the output.
  always_ff @(posedge sys_clk) begin
    if (w_stop_ok && !w_word_full) begin
      r_asm[{r_byte_cnt[2:0], 3'b000} +: 8] <= r_shift;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_byte_cnt <= 4'd0;
    end else if (w_stop_ok) begin
      r_byte_cnt <= w_word_full ? 4'd0 : r_byte_cnt + 4'd1;
    end else if (w_stop_bad || w_to_fire) begin
      r_byte_cnt <= 4'd0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_idle_tmr <= '0;
    end else if (!w_tmr_run || w_to_fire) begin
      r_idle_tmr <= '0;
    end else begin
      r_idle_tmr <= r_idle_tmr + 1'b1;
    end
  end

  // Output registers. Each pulse comes from its own exclusive event, so at
  // most one of them is high in any cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_uart_data <= 64'h0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done      <= w_stop_ok && w_word_full;
      r_frame_err <= w_stop_bad;
      r_timeout   <= w_to_fire;
      if (w_stop_ok && w_word_full) begin
        r_uart_data <= {r_shift, r_asm};
      end
    end
  end

  assign uart_done = r_done;
  assign uart_data = r_uart_data;
  assign byte_cnt  = r_byte_cnt;
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_p_uart_recv.sv
`timescale 1ns/1ps
module tb_p_uart_recv;

  localparam int CLK_FREQ     = 1000000;
  localparam int UART_BPS     = 100000;
  localparam int TIMEOUT_BITS = 20;
  localparam int BPS          = CLK_FREQ / UART_BPS;
  localparam int TO_CLKS      = TIMEOUT_BITS * BPS;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_rxd  = 1'b1;
  logic        uart_done;
  logic [63:0] uart_data;
  logic        rx_busy;
  logic [3:0]  byte_cnt;
  logic        frame_err;
  logic        timeout;

  p_uart_recv #(
    .CLK_FREQ     (CLK_FREQ),
    .UART_BPS     (UART_BPS),
    .TIMEOUT_BITS (TIMEOUT_BITS)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .uart_done (uart_done),
    .uart_data (uart_data),
    .rx_busy   (rx_busy),
    .byte_cnt  (byte_cnt),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the bytes of the word in progress, the words expected,
  // the expected event counts and the expected uart_data value
  logic [7:0]  mdl_bytes[$];
  logic [63:0] exp_words[$];
  logic [63:0] exp_data = 64'h0;
  int          exp_ferr = 0;
  int          exp_to   = 0;

  // Observed side
  logic [63:0] got_words[$];
  int          got_ferr   = 0;
  int          got_to     = 0;
  int          busy_rises = 0;
  longint      cyc        = 0;
  longint      fall_cyc   = 0;
  longint      to_cyc     = 0;
  logic        prev_any   = 1'b0;
  logic        prev_busy  = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (uart_done) got_words.push_back(uart_data);
    if (frame_err) got_ferr++;
    if (timeout) begin
      got_to++;
      to_cyc = cyc;
    end
    if (uart_done || frame_err || timeout) begin
      n_cmp++;
      assert (((int'(uart_done) + int'(frame_err) + int'(timeout)) == 1) && !prev_any)
      else begin
        n_err++;
        $error("FAIL pulse_excl: observed done/ferr/to=%b%b%b prev=%b expected exactly one, prev 0",
               uart_done, frame_err, timeout, prev_any);
      end
    end
    prev_any = uart_done || frame_err || timeout;
    if (prev_busy && !rx_busy) fall_cyc = cyc;
    if (!prev_busy && rx_busy) busy_rises++;
    prev_busy = rx_busy;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic line_bit(input logic v);
    uart_rxd = v;
    step(BPS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    logic [63:0] w;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop_ok);
    uart_rxd = 1'b1;
    if (stop_ok) begin
      mdl_bytes.push_back(b);
      if (mdl_bytes.size() == 8) begin
        w = 64'h0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mdl_bytes[i];
        exp_words.push_back(w);
        exp_data = w;
        mdl_bytes.delete();
      end
    end else begin
      mdl_bytes.delete();
      exp_ferr++;
    end
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_nwords"}, 64'(got_words.size()), 64'(exp_words.size()));
    while (got_words.size() > 0 && exp_words.size() > 0) begin
      chk({tag, "_word"}, got_words.pop_front(), exp_words.pop_front());
    end
    got_words.delete();
    exp_words.delete();
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_byte_cnt"}, 64'(byte_cnt), 64'(mdl_bytes.size()));
    chk({tag, "_ferr_cnt"}, 64'(got_ferr), 64'(exp_ferr));
    chk({tag, "_to_cnt"}, 64'(got_to), 64'(exp_to));
    chk({tag, "_data"}, uart_data, exp_data);
    chk({tag, "_busy"}, 64'(rx_busy), 64'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, uart_data, 64'h0);
    chk({tag, "_byte_cnt"}, 64'(byte_cnt), 64'h0);
    chk({tag, "_done"}, 64'(uart_done), 64'h0);
    chk({tag, "_ferr"}, 64'(frame_err), 64'h0);
    chk({tag, "_to"}, 64'(timeout), 64'h0);
    chk({tag, "_busy"}, 64'(rx_busy), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int         k;
    int         r0;

    // Reset state
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    step(4);
    check_reset("rst");
    sys_rst_n = 1'b1;
    step(5);

    // Eight bytes 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1);
      step(2);
    end
    step(3);
    check_words("seq");
    chk("seq_value", uart_data, 64'h0807060504030201);
    check_state("seq");

    // Short low glitch with a partial word pending
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    step(3);
    r0 = busy_rises;
    uart_rxd = 1'b0;
    step(3);
    uart_rxd = 1'b1;
    step(20);
    chk("glitch_busy_seen", 64'(busy_rises - r0), 64'd1);
    check_state("glitch");

    // Frame error abandons the word, then a good word
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'($urandom), 1'b0);
    step(3);
    check_state("ferr");
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 17), 1'b1);
    step(3);
    check_words("after_ferr");
    chk("after_ferr_value", uart_data, 64'h8877665544332211);
    check_state("after_ferr");

    // Idle timeout with three bytes pending
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    k = 0;
    while (got_to == exp_to && k < 2 * TO_CLKS) begin
      step(1);
      k++;
    end
    exp_to++;
    mdl_bytes.delete();
    chk("to_latency", 64'(to_cyc - fall_cyc), 64'(TO_CLKS));
    step(3);
    check_state("timeout");

    // Reset during bit 4 of byte 5
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b1);
    rb = 8'($urandom);
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(rb[i]);
    uart_rxd = rb[4];
    step(BPS / 2);
    sys_rst_n = 1'b0;
    uart_rxd  = 1'b1;
    step(3);
    check_reset("mid_rst");
    mdl_bytes.delete();
    exp_data = 64'h0;
    sys_rst_n = 1'b1;
    step(TO_CLKS + 50);
    check_state("post_rst");
    for (int i = 0; i < 8; i++) send_byte(8'hFF, 1'b1);
    step(3);
    check_words("ff");
    chk("ff_value", uart_data, 64'hFFFFFFFFFFFFFFFF);
    check_state("ff");

    // 16 back-to-back bytes, no idle between frames
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b1);
    step(3);
    chk("b2b_nwords_pre", 64'(got_words.size()), 64'd2);
    check_words("b2b");
    check_state("b2b");

    // Random frames, random gaps, occasional bad stop bit
    for (int i = 0; i < 24; i++) begin
      send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
      step($urandom_range(0, 40));
    end
    step(3);
    check_words("rand");
    check_state("rand");

    // Line held low (break): one framing error, no restart while low
    uart_rxd = 1'b0;
    step(15 * BPS);
    uart_rxd = 1'b1;
    step(20);
    exp_ferr++;
    mdl_bytes.delete();
    check_state("break");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
